mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit beside the ALU in the MIPS execute stage. It takes the same A/B register operands as the ALU and runs MULT, MULTU, DIV and DIVU over multiple cycles. Results go into internal HI/LO registers, which feed the write-back mux for MFHI/MFLO. The controller sees a start/busy/done handshake and stalls the pipeline while busy.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation:
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
- `A`  in  WIDTH  operand; dividend for divide.
- `B`  in  WIDTH  operand; divisor for divide.
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse; HI/LO updated on the same edge.
- `hi`  out  WIDTH  upper product word, or remainder.
- `lo`  out  WIDTH  lower product word, or quotient.
- `div_by_zero`  out  1  qualifies `done`; divide with B==0.

## Operation
- States:
  - IDLE: if `start` is high, latch A, B and op, clear the counter, go to RUN.
  - RUN: one iteration per cycle. After the counter reaches WIDTH-1, go to DONE.
  - DONE: go to IDLE.
- `busy` = (state==RUN). `done` = (state==DONE). Both are registered state decodes.
- Signed ops convert operands to magnitudes at latch time. Sign correction is applied combinationally before HI/LO are written.
- Multiply: shift-add on the magnitudes.
  - {hi,lo} = 64-bit product.
  - MULT negates the product when the operand signs differ.
- Divide: restoring algorithm, one quotient bit per cycle.
  - lo = quotient, hi = remainder.
  - DIV quotient sign = sign(A)^sign(B). Remainder sign = sign(A).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Wrap is accepted; no trap.
- Divide by zero: full latency is kept. Result is hi=A (original, unsigned-as-latched), lo=0xFFFFFFFF, and `div_by_zero`=1 during `done`.
- `start` in RUN or DONE is ignored; it is not queued.
- Operand changes after the latch cycle have no effect.
- HI/LO hold their value until the next completing operation.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `div_by_zero`=0
  - `hi`=0, `lo`=0
  - state=IDLE, counter=0
- `start` is sampled at edge k:
  - `busy` is high in cycles k+1 .. k+WIDTH (32 cycles).
  - `done` and `div_by_zero` are high in cycle k+WIDTH+1.
  - New `hi`/`lo` are visible from cycle k+WIDTH+1.
- Back-to-back: the next `start` is accepted at the edge ending the DONE cycle's successor (IDLE). Minimum issue interval is WIDTH+2 cycles.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values asynchronously, and no `done` is produced.

## Configuration
- `MDU_DIVIDER_EN` defined: the full divide datapath is built and all four ops behave as above.
- `MDU_DIVIDER_EN` undefined: the divide datapath is removed.
  - op 10/11 is accepted and goes IDLE→DONE directly, so `done` arrives at k+1 and `busy` never asserts.
  - HI/LO are unchanged and `div_by_zero`=0.
  - Multiply behaviour and timing are unchanged.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`
  - state enum `IDLE`/`RUN`/`DONE`
  - `MDU_WIDTH`=32 and the counter width `$clog2(MDU_WIDTH)`
- Sub-module `mdu_sign_adjust` (combinational) does magnitude extraction and final sign correction. It is shared by the multiply and divide paths.
- The top level holds the FSM, counter, iteration datapath and HI/LO registers.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 cycles `done`=1, hi=0xFFFFFFFE, lo=0x00000001. `busy` is high for exactly 32 cycles.
- MULT A=100, B=0xFFFFFF38 (-200) → hi=0xFFFFFFFF, lo=0xFFFFB1E0. Then MULT A=-1, B=-1 → hi=0, lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=200, B=100 → lo=2, hi=0.
- DIVU A=100, B=0 → hi=100, lo=0xFFFFFFFF, `div_by_zero`=1 with `done`. A following MULTU 3×4 gives `div_by_zero`=0, lo=12.
- `start` pulsed again in RUN cycle 5 with different operands → ignored; the first result completes unchanged. Then `rst_n` is dropped at RUN cycle 10 → `busy`=0 and hi=lo=0 immediately, with no `done`.
- Build without `MDU_DIVIDER_EN`: DIVU 200/100 → `done` at k+1, `busy` never high, HI/LO retain their prior values.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, op encodings and FSM states for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W     = $clog2(MDU_WIDTH);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_sign_adjust.sv
// rtl/mdu_sign_adjust.sv - operand magnitude extraction and final result sign correction
//
// Ports:
//   a, b       raw operands from the register file
//   is_signed  operation treats operands as two's complement
//   a_mag/b_mag, a_neg/b_neg  magnitudes and sign flags to be latched
//   raw        unsigned iteration result {upper, lower}
//   is_div     raw holds {remainder, quotient} rather than a product
//   sa, sb     latched operand sign flags
//   res_hi/res_lo  sign-corrected values for HI/LO
module mdu_sign_adjust
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               a_neg,
    output logic               b_neg,
    input  logic [2*WIDTH-1:0] raw,
    input  logic               is_div,
    input  logic               sa,
    input  logic               sb,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic [2*WIDTH-1:0] raw_neg;

    always_comb begin
        a_neg   = is_signed & a[WIDTH-1];
        b_neg   = is_signed & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        raw_neg = -raw;
        res_hi  = raw[2*WIDTH-1:WIDTH];
        res_lo  = raw[WIDTH-1:0];
        if (is_div) begin
            // Quotient takes the XOR of signs; remainder follows the dividend.
            if (sa ^ sb) res_lo = -raw[WIDTH-1:0];
            if (sa)      res_hi = -raw[2*WIDTH-1:WIDTH];
        end else if (sa ^ sb) begin
            res_hi = raw_neg[2*WIDTH-1:WIDTH];
            res_lo = raw_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Build option: MDU_DIVIDER_EN (define to build the divide datapath; when
// undefined, divide ops complete immediately leaving HI/LO untouched).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        request and operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   A, B             operands (dividend, divisor for divide)
//   busy, done       iterating / one-cycle completion pulse
//   hi, lo           result registers
//   div_by_zero      qualifies done for a divide by zero
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    // Shared iteration register: {partial product, multiplier} or {remainder, quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   opb;
    logic               sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               is_div_sel;
    logic               op_is_div;
    logic               op_is_signed;

`ifdef MDU_DIVIDER_EN
    logic               is_div_q;
    logic [WIDTH-1:0]   a_raw;
    logic               b_zero;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign op_is_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign op_is_signed = (op == OP_MULT) || (op == OP_DIV);

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIVIDER_EN
        // Restoring step: shift the next dividend bit into the remainder and
        // keep the subtraction only if it did not go negative.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        if (!div_diff[WIDTH+1])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        acc_next   = is_div_q ? div_next : mul_next;
        is_div_sel = is_div_q;
`else
        acc_next   = mul_next;
        is_div_sel = 1'b0;
`endif
    end

    mdu_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
        .a         (A),
        .b         (B),
        .is_signed (op_is_signed),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .raw       (acc_next),
        .is_div    (is_div_sel),
        .sa        (sa),
        .sb        (sb),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MDU_DIVIDER_EN
            is_div_q    <= 1'b0;
            a_raw       <= '0;
            b_zero      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        cnt <= '0;
                        acc <= {{WIDTH{1'b0}}, a_mag};
                        opb <= b_mag;
                        sa  <= a_neg;
                        sb  <= b_neg;
`ifdef MDU_DIVIDER_EN
                        is_div_q <= op_is_div;
                        a_raw    <= A;
                        b_zero   <= (B == '0);
                        state    <= RUN;
                        busy     <= 1'b1;
`else
                        if (op_is_div) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef MDU_DIVIDER_EN
                        if (is_div_q && b_zero) begin
                            hi          <= a_raw;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
`else
                        hi <= res_hi;
                        lo <= res_lo;
`endif
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: MIPS semantics with plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        int     sq, sr;
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                x = $signed(a);
                y = $signed(b);
                return x * y;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
        endcase
    endfunction

    // Issues one op and collects what came back; cycle index 1 is the cycle after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz,
                          output int dcyc, output int bcnt, output logic dafter);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);
        dcyc = -1; bcnt = 0; rhi = 'x; rlo = 'x; rdbz = 1'bx;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                dcyc = c; rhi = hi; rlo = lo; rdbz = div_by_zero;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        @(negedge clk);
        dafter = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, div_by_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h required all zero", busy, done, div_by_zero, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        logic [31:0] rh, rl; logic rd, da; int dc, bc;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rd, dc, bc, da);
        total++;
        if (dc !== 33) begin bad++; $display("FAIL multu_max_latency: done_cycle=%0d required 33", dc); end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL multu_max_busy: busy_cycles=%0d required 32", bc); end
        total++;
        if (rh !== 32'hFFFFFFFE || rl !== 32'h00000001) begin
            bad++; $display("FAIL multu_max_result: hi=%h lo=%h required fffffffe 00000001", rh, rl);
        end
        total++;
        if (da !== 1'b0 || rd !== 1'b0) begin bad++; $display("FAIL multu_max_pulse: done_after=%b dbz=%b required 0 0", da, rd); end
    endtask

    task automatic test_mult_signed;
        logic [31:0] rh, rl; logic rd, da; int dc, bc;
        run_op(2'b01, 32'd100, 32'hFFFFFF38, rh, rl, rd, dc, bc, da);
        total++;
        if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFB1E0 || dc !== 33) begin
            bad++; $display("FAIL mult_neg: hi=%h lo=%h cyc=%0d required ffffffff ffffb1e0 33", rh, rl, dc);
        end
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rd, dc, bc, da);
        total++;
        if (rh !== 32'h0 || rl !== 32'h1) begin
            bad++; $display("FAIL mult_m1m1: hi=%h lo=%h required 0 1", rh, rl);
        end
    endtask

    task automatic test_mult_random;
        logic [31:0] rh, rl, a, b; logic rd, da; int dc, bc; logic [1:0] o; logic [63:0] exp;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h0;
            exp = ref_mdu(o, a, b);
            run_op(o, a, b, rh, rl, rd, dc, bc, da);
            total++;
            if ({rh, rl} !== exp || dc !== 33 || rd !== 1'b0) begin
                bad++;
                $display("FAIL mult_rand op=%0d a=%h b=%h: got %h_%h cyc=%0d dbz=%b required %h cyc=33 dbz=0", o, a, b, rh, rl, dc, rd, exp);
            end
        end
    endtask

`ifdef MDU_DIVIDER_EN
    task automatic test_divide;
        logic [31:0] rh, rl, a, b; logic rd, da; int dc, bc; logic [1:0] o; logic [63:0] exp;
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, rh, rl, rd, dc, bc, da);
        total++;
        if (rl !== 32'hFFFFFFFD || rh !== 32'hFFFFFFFF || dc !== 33) begin
            bad++; $display("FAIL div_m7_2: hi=%h lo=%h cyc=%0d required ffffffff fffffffd 33", rh, rl, dc);
        end
        run_op(2'b10, 32'd200, 32'd100, rh, rl, rd, dc, bc, da);
        total++;
        if (rl !== 32'd2 || rh !== 32'd0 || bc !== 32) begin
            bad++; $display("FAIL divu_200_100: hi=%h lo=%h busy=%0d required 0 2 32", rh, rl, bc);
        end
        run_op(2'b10, 32'd100, 32'd0, rh, rl, rd, dc, bc, da);
        total++;
        if (rh !== 32'd100 || rl !== 32'hFFFFFFFF || rd !== 1'b1 || dc !== 33) begin
            bad++; $display("FAIL divu_by_zero: hi=%h lo=%h dbz=%b cyc=%0d required 64 ffffffff 1 33", rh, rl, rd, dc);
        end
        run_op(2'b00, 32'd3, 32'd4, rh, rl, rd, dc, bc, da);
        total++;
        if (rl !== 32'd12 || rd !== 1'b0) begin
            bad++; $display("FAIL multu_after_dbz: lo=%h dbz=%b required c 0", rl, rd);
        end
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, rh, rl, rd, dc, bc, da);
        total++;
        if (rl !== 32'h80000000 || rh !== 32'h0) begin
            bad++; $display("FAIL div_overflow: hi=%h lo=%h required 0 80000000", rh, rl);
        end
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(2, 3));
            a = $urandom; b = (i % 5 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            exp = ref_mdu(o, a, b);
            run_op(o, a, b, rh, rl, rd, dc, bc, da);
            total++;
            if ({rh, rl} !== exp || rd !== (b == 0) || dc !== 33) begin
                bad++;
                $display("FAIL div_rand op=%0d a=%h b=%h: got %h_%h dbz=%b cyc=%0d required %h dbz=%b cyc=33", o, a, b, rh, rl, rd, dc, exp, (b == 0));
            end
        end
    endtask
`else
    task automatic test_divide;
        logic [31:0] rh, rl, ph, pl; logic rd, da; int dc, bc;
        run_op(2'b00, 32'd7, 32'd9, ph, pl, rd, dc, bc, da);
        run_op(2'b10, 32'd200, 32'd100, rh, rl, rd, dc, bc, da);
        total++;
        if (dc !== 1 || bc !== 0) begin
            bad++; $display("FAIL nodiv_timing: done_cycle=%0d busy_cycles=%0d required 1 0", dc, bc);
        end
        total++;
        if (rh !== 32'd0 || rl !== 32'd63 || rd !== 1'b0) begin
            bad++; $display("FAIL nodiv_hold: hi=%h lo=%h dbz=%b required 0 3f 0", rh, rl, rd);
        end
        run_op(2'b11, 32'd5, 32'd0, rh, rl, rd, dc, bc, da);
        total++;
        if (dc !== 1 || rd !== 1'b0 || rl !== 32'd63 || da !== 1'b0) begin
            bad++; $display("FAIL nodiv_zero: cyc=%0d dbz=%b lo=%h done_after=%b required 1 0 3f 0", dc, rd, rl, da);
        end
    endtask
`endif

    task automatic test_start_ignored;
        logic [63:0] exp; int dc;
        exp = ref_mdu(2'b01, 32'hFFFF1234, 32'h00054321);
        @(negedge clk);
        op = 2'b01; A = 32'hFFFF1234; B = 32'h00054321; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5) begin op = 2'b00; A = 32'd11; B = 32'd13; start = 1'b1; end
            if (c == 6) start = 1'b0;
            if (done) begin dc = c; break; end
            @(negedge clk);
        end
        total++;
        if (dc !== 33 || {hi, lo} !== exp) begin
            bad++; $display("FAIL start_in_run: cyc=%0d got %h_%h required 33 %h", dc, hi, lo, exp);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL start_not_queued: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        op = 2'b00; A = 32'd123; B = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        seen = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL reset_no_done: activity after abort=%b required 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_mult_signed;
        test_mult_random;
        test_divide;
        test_start_ignored;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
